// File: rtl/pattern_seq_ctrl.sv
// Frame-synchronous test-pattern selector for the HDMI pattern generator.
// Pattern switches (host request or auto-cycle) are applied only at VS rising edges, with optional blanking.
//
// state | meaning
// SYNC  | after reset, waiting for the first frame boundary; outputs held at reset values
// RUN   | pattern active; host requests accepted; auto-cycle hold counter running
// MUTE  | blank asserted for MUTE_FRAMES boundaries after a switch; requests refused
module pattern_seq_ctrl #(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int MUTE_FRAMES        = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vs,
    input  logic             auto_en,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic [SEL_W-1:0] pat_sel,
    output logic             pat_upd,
    output logic             blank,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        MUTE = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [15:0]      HOLD_LAST = 16'(FRAMES_PER_PATTERN - 1);
    localparam logic [15:0]      MUTE_LEN  = 16'(MUTE_FRAMES);

    state_t           state, state_nx;
    logic             vs_q;
    logic             fb;
    logic             accept;
    logic [SEL_W-1:0] sel_clamp;
    logic [SEL_W-1:0] sel_wrap;

    logic [15:0]      hold, hold_nx;
    logic [15:0]      mute_cnt, mute_cnt_nx;
    logic             pend, pend_nx;
    logic [SEL_W-1:0] pend_sel, pend_sel_nx;
    logic [SEL_W-1:0] pat_sel_nx;
    logic             pat_upd_nx;
    logic             blank_nx;
    logic [15:0]      frame_cnt_nx;

    logic             do_switch;
    logic [SEL_W-1:0] switch_sel;

    assign fb        = vs & ~vs_q;
    assign req_ready = (state == RUN) & ~pend;
    assign accept    = req_valid & req_ready;
    assign sel_clamp = (req_sel > MAX_SEL) ? MAX_SEL : req_sel;
    assign sel_wrap  = (pat_sel >= MAX_SEL) ? '0 : pat_sel + SEL_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SYNC;
            vs_q      <= 1'b0;
            hold      <= '0;
            mute_cnt  <= '0;
            pend      <= 1'b0;
            pend_sel  <= '0;
            pat_sel   <= '0;
            pat_upd   <= 1'b0;
            blank     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            vs_q      <= vs;
            hold      <= hold_nx;
            mute_cnt  <= mute_cnt_nx;
            pend      <= pend_nx;
            pend_sel  <= pend_sel_nx;
            pat_sel   <= pat_sel_nx;
            pat_upd   <= pat_upd_nx;
            blank     <= blank_nx;
            frame_cnt <= frame_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hold_nx      = hold;
        mute_cnt_nx  = mute_cnt;
        pend_nx      = pend;
        pend_sel_nx  = pend_sel;
        pat_sel_nx   = pat_sel;
        pat_upd_nx   = 1'b0;
        blank_nx     = blank;
        frame_cnt_nx = frame_cnt;
        do_switch    = 1'b0;
        switch_sel   = pat_sel;

        if (fb) begin
            frame_cnt_nx = frame_cnt + 16'd1;
        end

        // A request accepted on a boundary cycle is only seen at the following boundary
        if (accept) begin
            pend_nx     = 1'b1;
            pend_sel_nx = sel_clamp;
        end

        case (state)
            SYNC: begin
                if (fb) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (fb) begin
                    if (pend) begin
                        do_switch  = 1'b1;
                        switch_sel = pend_sel;
                        pend_nx    = 1'b0;
                    end else if (auto_en && (hold >= HOLD_LAST)) begin
                        do_switch  = 1'b1;
                        switch_sel = sel_wrap;
                    end

                    if (do_switch) begin
                        pat_sel_nx = switch_sel;
                        pat_upd_nx = 1'b1;
                        hold_nx    = '0;
                        if (MUTE_FRAMES > 0) begin
                            blank_nx    = 1'b1;
                            mute_cnt_nx = MUTE_LEN;
                            state_nx    = MUTE;
                        end
                    end else if (auto_en) begin
                        hold_nx = hold + 16'd1;
                    end
                end
            end
            MUTE: begin
                if (fb) begin
                    if (auto_en) begin
                        hold_nx = hold + 16'd1;
                    end
                    if (mute_cnt <= 16'd1) begin
                        blank_nx    = 1'b0;
                        mute_cnt_nx = '0;
                        state_nx    = RUN;
                    end else begin
                        mute_cnt_nx = mute_cnt - 16'd1;
                    end
                end
            end
            default: begin
                state_nx = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Scoreboard bench for pattern_seq_ctrl: two instances (A: 4 patterns, 1 mute frame; B: 3 patterns, no mute).
// Expected pattern switches are queued at stimulus time and popped by a monitor on every pat_upd pulse.
module tb_pattern_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vs;
    logic        a_auto, a_valid, b_auto, b_valid;
    logic [1:0]  a_sel, b_sel;
    logic        a_ready, a_upd, a_blank, b_ready, b_upd, b_blank;
    logic [1:0]  a_pat, b_pat;
    logic [15:0] a_fc, b_fc;

    int checks   = 0;
    int failures = 0;
    int exp_fc   = 0;
    logic [1:0] exp_a[$];
    logic [1:0] exp_b[$];
    logic a_upd_prev = 1'b0;
    logic b_upd_prev = 1'b0;

    always #5 clk = ~clk;

    pattern_seq_ctrl #(.NUM_PATTERNS(4), .SEL_W(2), .FRAMES_PER_PATTERN(3), .MUTE_FRAMES(1)) dut_a (
        .clk(clk), .rstn(rstn), .vs(vs), .auto_en(a_auto), .req_valid(a_valid), .req_sel(a_sel),
        .req_ready(a_ready), .pat_sel(a_pat), .pat_upd(a_upd), .blank(a_blank), .frame_cnt(a_fc)
    );

    pattern_seq_ctrl #(.NUM_PATTERNS(3), .SEL_W(2), .FRAMES_PER_PATTERN(3), .MUTE_FRAMES(0)) dut_b (
        .clk(clk), .rstn(rstn), .vs(vs), .auto_en(b_auto), .req_valid(b_valid), .req_sel(b_sel),
        .req_ready(b_ready), .pat_sel(b_pat), .pat_upd(b_upd), .blank(b_blank), .frame_cnt(b_fc)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every pat_upd pulse must match the next queued switch
    always @(negedge clk) begin
        if (rstn) begin
            if (a_upd) begin
                chk("a_upd_single_cycle", int'(a_upd_prev), 0);
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_upd actual_pat=%0d required=no_pulse t=%0t", a_pat, $time);
                end else begin
                    chk("a_pat_sel", int'(a_pat), int'(exp_a.pop_front()));
                    chk("a_blank_on_upd", int'(a_blank), 1);
                end
            end
            if (b_upd) begin
                chk("b_upd_single_cycle", int'(b_upd_prev), 0);
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_upd actual_pat=%0d required=no_pulse t=%0t", b_pat, $time);
                end else begin
                    chk("b_pat_sel", int'(b_pat), int'(exp_b.pop_front()));
                    chk("b_blank_on_upd", int'(b_blank), 0);
                end
            end
        end
        a_upd_prev <= rstn & a_upd;
        b_upd_prev <= rstn & b_upd;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        @(posedge clk); #1;
        vs = 1'b1;
        @(posedge clk); #1;
        vs = 1'b0;
        exp_fc++;
        cyc(4);
    endtask

    task automatic issue_req(input bit is_b, input logic [1:0] sel, input logic [1:0] expv);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (is_b) begin b_valid = 1'b1; b_sel = sel; end
        else      begin a_valid = 1'b1; a_sel = sel; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_b ? b_ready : a_ready) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (got) begin
            if (is_b) exp_b.push_back(expv);
            else      exp_a.push_back(expv);
        end else begin
            checks++;
            failures++;
            $display("FAIL req_timeout actual=no_ready required=ready dut_b=%0d t=%0t", is_b, $time);
        end
    endtask

    // Request accepted on the same edge as a frame boundary
    task automatic fb_with_req(input bit is_b, input logic [1:0] sel);
        @(posedge clk); #1;
        vs = 1'b1;
        if (is_b) begin b_valid = 1'b1; b_sel = sel; end
        else      begin a_valid = 1'b1; a_sel = sel; end
        @(negedge clk);
        chk("fbreq_ready", int'(is_b ? b_ready : a_ready), 1);
        @(posedge clk); #1;
        vs = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp_fc++;
        cyc(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; vs = 1'b0;
        a_auto = 1'b0; a_valid = 1'b0; a_sel = 2'd0;
        b_auto = 1'b0; b_valid = 1'b0; b_sel = 2'd0;

        // T1 reset and SYNC
        cyc(3);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_a_pat", int'(a_pat), 0);
        chk("rst_a_upd", int'(a_upd), 0);
        chk("rst_a_blank", int'(a_blank), 0);
        chk("rst_a_fc", int'(a_fc), 0);
        chk("rst_b_ready", int'(b_ready), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(3);
        chk("sync_a_ready", int'(a_ready), 0);
        chk("sync_b_ready", int'(b_ready), 0);
        frame();
        chk("run_a_ready", int'(a_ready), 1);
        chk("run_b_ready", int'(b_ready), 1);
        chk("run_a_pat", int'(a_pat), 0);
        chk("run_a_blank", int'(a_blank), 0);
        chk("run_a_fc", int'(a_fc), exp_fc);

        // T2 manual request with one mute frame
        issue_req(1'b0, 2'd2, 2'd2);
        chk("t2_ready_fall", int'(a_ready), 0);
        chk("t2_pat_before_fb", int'(a_pat), 0);
        frame();
        chk("t2_pat", int'(a_pat), 2);
        chk("t2_blank", int'(a_blank), 1);
        chk("t2_ready_mute", int'(a_ready), 0);
        cyc(3);
        chk("t2_blank_hold", int'(a_blank), 1);
        frame();
        chk("t2_blank_clear", int'(a_blank), 0);
        chk("t2_ready_back", int'(a_ready), 1);

        // T4 pending request collides with auto expiry
        a_auto = 1'b1;
        frame();
        frame();
        issue_req(1'b0, 2'd1, 2'd1);
        frame();
        chk("t4_pat_req_wins", int'(a_pat), 1);
        chk("t4_blank", int'(a_blank), 1);
        exp_a.push_back(2'd2);
        frame();
        chk("t4_mute_exit", int'(a_blank), 0);
        frame();
        chk("t4_no_early_step", int'(a_pat), 1);
        frame();
        chk("t4_auto_step", int'(a_pat), 2);
        chk("t4_auto_blank", int'(a_blank), 1);
        a_auto = 1'b0;
        frame();
        chk("t4_blank_clear", int'(a_blank), 0);

        // T5 same-value request still switches and blanks
        issue_req(1'b0, 2'd2, 2'd2);
        frame();
        chk("t5_same_pat", int'(a_pat), 2);
        chk("t5_same_blank", int'(a_blank), 1);
        frame();
        chk("t5_blank_clear", int'(a_blank), 0);
        chk("t5_a_fc", int'(a_fc), exp_fc);

        // T3 auto wrap on B (3 patterns, no mute)
        b_auto = 1'b1;
        exp_b.push_back(2'd1);
        exp_b.push_back(2'd2);
        exp_b.push_back(2'd0);
        exp_b.push_back(2'd1);
        repeat (14) frame();
        chk("t3_b_pat", int'(b_pat), 1);
        chk("t3_b_blank", int'(b_blank), 0);
        b_auto = 1'b0;
        repeat (3) frame();
        chk("t3_frozen", int'(b_pat), 1);
        b_auto = 1'b1;
        exp_b.push_back(2'd2);
        frame();
        chk("t3_resume", int'(b_pat), 2);
        b_auto = 1'b0;

        // Clamp of out-of-range request on B
        issue_req(1'b1, 2'd0, 2'd0);
        frame();
        chk("clamp_pre", int'(b_pat), 0);
        issue_req(1'b1, 2'd3, 2'd2);
        frame();
        chk("clamp_pat", int'(b_pat), 2);
        chk("b_fc", int'(b_fc), exp_fc);

        // Request accepted on the boundary edge is deferred one frame
        fb_with_req(1'b0, 2'd1);
        chk("defer_pat", int'(a_pat), 2);
        chk("defer_ready", int'(a_ready), 0);
        exp_a.push_back(2'd1);
        frame();
        chk("defer_applied", int'(a_pat), 1);
        frame();
        chk("defer_blank_clear", int'(a_blank), 0);

        // T6 reset while muted with a request pending
        a_auto = 1'b1;
        frame();
        frame();
        exp_a.push_back(2'd2);
        fb_with_req(1'b0, 2'd3);
        chk("t6_pat_pre", int'(a_pat), 2);
        chk("t6_blank_pre", int'(a_blank), 1);
        a_auto = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #2;
        chk("t6_rst_pat", int'(a_pat), 0);
        chk("t6_rst_blank", int'(a_blank), 0);
        chk("t6_rst_ready", int'(a_ready), 0);
        chk("t6_rst_upd", int'(a_upd), 0);
        chk("t6_rst_fc", int'(a_fc), 0);
        chk("t6_rst_b_pat", int'(b_pat), 0);
        exp_fc = 0;
        cyc(2);
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(2);
        frame();
        frame();
        frame();
        chk("t6_after_pat", int'(a_pat), 0);
        chk("t6_after_ready", int'(a_ready), 1);
        chk("t6_after_blank", int'(a_blank), 0);
        chk("t6_after_a_fc", int'(a_fc), exp_fc);
        chk("t6_after_b_fc", int'(b_fc), exp_fc);

        cyc(2);
        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
